// File: rtl/rvj1_mem_arb.sv
// rvj1 single-port memory arbiter: IFU and LSU share one mem port, one
// outstanding transaction. Ports: ifu_*/lsu_* requesters, mem_* memory side.
module rvj1_mem_arb #(
  parameter int XLEN           = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [XLEN-1:0]   ifu_addr_i,
  input  logic              ifu_flush_i,
  output logic              ifu_rsp_valid_o,
  output logic [XLEN-1:0]   ifu_rsp_data_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic              lsu_we_i,
  input  logic [XLEN/8-1:0] lsu_be_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_rsp_valid_o,
  output logic [XLEN-1:0]   lsu_rsp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_data_i
);

  localparam int BEW = XLEN / 8;
  localparam int SW  = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            drop_q, drop_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [BEW-1:0]  be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [XLEN-1:0] ifu_rsp_data_q, ifu_rsp_data_d;
  logic            lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [XLEN-1:0] lsu_rsp_data_q, lsu_rsp_data_d;

  logic idle;
  logic lsu_win;
  logic ifu_win;

  // Once the LSU has won MAX_LSU_STREAK contested rounds, a waiting
  // fetch takes the next grant.
  assign idle    = (state_q == IDLE);
  assign lsu_win = lsu_req_valid_i &&
                   !(ifu_req_valid_i && (streak_q == SMAX));
  assign ifu_win = !lsu_win && ifu_req_valid_i;

  assign lsu_req_ready_o = idle && lsu_win;
  assign ifu_req_ready_o = idle && ifu_win;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    streak_d        = streak_q;
    drop_d          = drop_q;
    mem_req_valid_d = mem_req_valid_q;
    addr_d          = addr_q;
    we_d            = we_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_data_d  = ifu_rsp_data_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_data_d  = lsu_rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (lsu_win) begin
          state_d         = REQ;
          owner_d         = OWN_LSU;
          mem_req_valid_d = 1'b1;
          addr_d          = lsu_addr_i;
          we_d            = lsu_we_i;
          be_d            = lsu_be_i;
          wdata_d         = lsu_wdata_i;
          if (ifu_req_valid_i && (streak_q < SMAX))
            streak_d = streak_q + SW'(1);
        end else if (ifu_win) begin
          state_d         = REQ;
          owner_d         = OWN_IFU;
          mem_req_valid_d = 1'b1;
          addr_d          = ifu_addr_i;
          we_d            = 1'b0;
          be_d            = '1;
          wdata_d         = '0;
          streak_d        = '0;
        end
      end
      REQ: begin
        if (owner_q == OWN_IFU && ifu_flush_i)
          drop_d = 1'b1;
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (owner_q == OWN_IFU && ifu_flush_i)
          drop_d = 1'b1;
        if (mem_rsp_valid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_LSU) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = mem_rsp_data_i;
          end else if (!(drop_q || ifu_flush_i)) begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = mem_rsp_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IFU;
      streak_q        <= '0;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      be_q            <= '0;
      wdata_q         <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      streak_q        <= streak_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = addr_q;
  assign mem_we_o        = we_q;
  assign mem_be_o        = be_q;
  assign mem_wdata_o     = wdata_q;
  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign ifu_rsp_data_o  = ifu_rsp_data_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign lsu_rsp_data_o  = lsu_rsp_data_q;

endmodule

// File: tb/tb_rvj1_mem_arb.sv
// Testbench for rvj1_mem_arb: per-cycle vector table plus
// directed sequences for backpressure, flush, reset and streak limit.
module tb_rvj1_mem_arb;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ifu_req_valid_i;
  logic        ifu_req_ready_o;
  logic [31:0] ifu_addr_i;
  logic        ifu_flush_i;
  logic        ifu_rsp_valid_o;
  logic [31:0] ifu_rsp_data_o;
  logic        lsu_req_valid_i;
  logic        lsu_req_ready_o;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_rsp_valid_o;
  logic [31:0] lsu_rsp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  rvj1_mem_arb #(.XLEN(32), .MAX_LSU_STREAK(4)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .ifu_req_valid_i (ifu_req_valid_i),
    .ifu_req_ready_o (ifu_req_ready_o),
    .ifu_addr_i      (ifu_addr_i),
    .ifu_flush_i     (ifu_flush_i),
    .ifu_rsp_valid_o (ifu_rsp_valid_o),
    .ifu_rsp_data_o  (ifu_rsp_data_o),
    .lsu_req_valid_i (lsu_req_valid_i),
    .lsu_req_ready_o (lsu_req_ready_o),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_be_i        (lsu_be_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_rsp_valid_o (lsu_rsp_valid_o),
    .lsu_rsp_data_o  (lsu_rsp_data_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i)
  );

  typedef struct {
    bit          ifu_v;
    logic [31:0] ifu_a;
    bit          lsu_v;
    logic [31:0] lsu_a;
    logic [3:0]  lsu_be;
    bit          m_rdy;
    bit          r_v;
    logic [31:0] r_d;
    bit          e_ifu_rdy;
    bit          e_lsu_rdy;
    bit          e_mv;
    logic [31:0] e_ma;
    bit          e_mwe;
    logic [3:0]  e_mbe;
    bit          e_irv;
    logic [31:0] e_ird;
    bit          e_lrv;
    logic [31:0] e_lrd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    ifu_req_valid_i = 1'b0;
    ifu_addr_i      = '0;
    ifu_flush_i     = 1'b0;
    lsu_req_valid_i = 1'b0;
    lsu_addr_i      = '0;
    lsu_we_i        = 1'b0;
    lsu_be_i        = '0;
    lsu_wdata_i     = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rstn_i = 1'b0;
    clr_inputs();
    next_cycle();
    rstn_i = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit fl_req,
                       input bit fl_wait, input logic [31:0] d,
                       input bit exp_pulse, input string nm);
    next_cycle();
    ifu_req_valid_i = 1'b1;
    ifu_addr_i      = a;
    @(negedge clk_i);
    chk({nm, " ifu_rdy"}, 32'(ifu_req_ready_o), 32'd1);
    next_cycle();
    ifu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    ifu_flush_i     = fl_req;
    @(negedge clk_i);
    chk({nm, " mem_addr"}, mem_addr_o, a);
    next_cycle();
    mem_req_ready_i = 1'b0;
    ifu_flush_i     = fl_wait;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    next_cycle();
    ifu_flush_i     = 1'b0;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk({nm, " ifu_rsp_v"}, 32'(ifu_rsp_valid_o), 32'(exp_pulse));
    chk({nm, " lsu_rsp_v"}, 32'(lsu_rsp_valid_o), 32'd0);
    if (exp_pulse)
      chk({nm, " ifu_rsp_d"}, ifu_rsp_data_o, d);
  endtask

  initial begin
    bit          g [10];
    int          ng;
    bit          acc;
    rstn_i = 1'b0;
    clr_inputs();

    //        ifu_v ifu_a   lsu_v lsu_a   be    rdy rv rd
    //        irdy lrdy mv  ma     we be    irv ird  lrv lrd
    tbl[0] = '{1, 32'h80, 1, 32'h200, 4'h5, 0, 0, 32'h0,
               0, 1, 0, 32'h0,   0, 4'h0, 0, 32'h0,  0, 32'h0};
    tbl[1] = '{1, 32'h80, 0, 32'h0,   4'h0, 1, 0, 32'h0,
               0, 0, 1, 32'h200, 0, 4'h5, 0, 32'h0,  0, 32'h0};
    tbl[2] = '{1, 32'h80, 0, 32'h0,   4'h0, 0, 1, 32'hCAFE0001,
               0, 0, 0, 32'h200, 0, 4'h5, 0, 32'h0,  0, 32'h0};
    tbl[3] = '{1, 32'h80, 0, 32'h0,   4'h0, 0, 0, 32'h0,
               1, 0, 0, 32'h200, 0, 4'h5, 0, 32'h0,  1, 32'hCAFE0001};
    tbl[4] = '{0, 32'h0,  0, 32'h0,   4'h0, 1, 0, 32'h0,
               0, 0, 1, 32'h80,  0, 4'hF, 0, 32'h0,  0, 32'hCAFE0001};
    tbl[5] = '{0, 32'h0,  0, 32'h0,   4'h0, 0, 1, 32'h13,
               0, 0, 0, 32'h80,  0, 4'hF, 0, 32'h0,  0, 32'hCAFE0001};
    tbl[6] = '{0, 32'h0,  0, 32'h0,   4'h0, 0, 0, 32'h0,
               0, 0, 0, 32'h80,  0, 4'hF, 1, 32'h13, 0, 32'hCAFE0001};
    tbl[7] = '{0, 32'h0,  0, 32'h0,   4'h0, 0, 0, 32'h0,
               0, 0, 0, 32'h80,  0, 4'hF, 0, 32'h13, 0, 32'hCAFE0001};

    // reset state
    do_reset();
    @(negedge clk_i);
    chk("rst mem_v", 32'(mem_req_valid_o), 32'd0);
    chk("rst mem_addr", mem_addr_o, 32'd0);
    chk("rst ifu_rsp_v", 32'(ifu_rsp_valid_o), 32'd0);
    chk("rst lsu_rsp_d", lsu_rsp_data_o, 32'd0);

    // vector table: LSU priority, then fetch path
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      ifu_req_valid_i = tbl[i].ifu_v;
      ifu_addr_i      = tbl[i].ifu_a;
      lsu_req_valid_i = tbl[i].lsu_v;
      lsu_addr_i      = tbl[i].lsu_a;
      lsu_be_i        = tbl[i].lsu_be;
      mem_req_ready_i = tbl[i].m_rdy;
      mem_rsp_valid_i = tbl[i].r_v;
      mem_rsp_data_i  = tbl[i].r_d;
      @(negedge clk_i);
      chk($sformatf("r%0d ifu_rdy", i), 32'(ifu_req_ready_o),
          32'(tbl[i].e_ifu_rdy));
      chk($sformatf("r%0d lsu_rdy", i), 32'(lsu_req_ready_o),
          32'(tbl[i].e_lsu_rdy));
      chk($sformatf("r%0d mem_v", i), 32'(mem_req_valid_o),
          32'(tbl[i].e_mv));
      chk($sformatf("r%0d mem_addr", i), mem_addr_o, tbl[i].e_ma);
      chk($sformatf("r%0d mem_we", i), 32'(mem_we_o),
          32'(tbl[i].e_mwe));
      chk($sformatf("r%0d mem_be", i), 32'(mem_be_o),
          32'(tbl[i].e_mbe));
      chk($sformatf("r%0d ifu_rsp_v", i), 32'(ifu_rsp_valid_o),
          32'(tbl[i].e_irv));
      chk($sformatf("r%0d ifu_rsp_d", i), ifu_rsp_data_o, tbl[i].e_ird);
      chk($sformatf("r%0d lsu_rsp_v", i), 32'(lsu_rsp_valid_o),
          32'(tbl[i].e_lrv));
      chk($sformatf("r%0d lsu_rsp_d", i), lsu_rsp_data_o, tbl[i].e_lrd);
    end

    // backpressure: store held stable for 5 stalled cycles
    do_reset();
    next_cycle();
    lsu_req_valid_i = 1'b1;
    lsu_addr_i      = 32'h0000_1000;
    lsu_we_i        = 1'b1;
    lsu_be_i        = 4'b0011;
    lsu_wdata_i     = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("bp lsu_rdy", 32'(lsu_req_ready_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      lsu_req_valid_i = 1'b0;
      lsu_addr_i      = 32'hFFFF_FFFF;
      lsu_we_i        = 1'b0;
      lsu_be_i        = 4'h0;
      lsu_wdata_i     = 32'h0;
      mem_req_ready_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("bp%0d mem_v", k), 32'(mem_req_valid_o), 32'd1);
      chk($sformatf("bp%0d addr", k), mem_addr_o, 32'h0000_1000);
      chk($sformatf("bp%0d wdata", k), mem_wdata_o, 32'hDEADBEEF);
      chk($sformatf("bp%0d be", k), 32'(mem_be_o), 32'h3);
      chk($sformatf("bp%0d we", k), 32'(mem_we_o), 32'd1);
    end
    next_cycle();
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp acc mem_v", 32'(mem_req_valid_o), 32'd1);
    next_cycle();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    chk("bp wait mem_v", 32'(mem_req_valid_o), 32'd0);
    chk("bp wait lsu_rsp_v", 32'(lsu_rsp_valid_o), 32'd0);
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bp lsu_rsp_v", 32'(lsu_rsp_valid_o), 32'd1);
    next_cycle();
    @(negedge clk_i);
    chk("bp lsu_rsp_v end", 32'(lsu_rsp_valid_o), 32'd0);

    // flush: in WAIT_RSP, in REQ, then a clean fetch
    do_reset();
    fetch(32'h100, 1'b0, 1'b1, 32'h12345678, 1'b0, "fl_wait");
    fetch(32'h104, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, "fl_req");
    fetch(32'h108, 1'b0, 1'b0, 32'h00000055, 1'b1, "fl_clean");

    // flush during an LSU transaction has no effect
    next_cycle();
    lsu_req_valid_i = 1'b1;
    lsu_addr_i      = 32'h300;
    @(negedge clk_i);
    chk("fl_lsu rdy", 32'(lsu_req_ready_o), 32'd1);
    next_cycle();
    lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    ifu_flush_i     = 1'b1;
    next_cycle();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hA5A5A5A5;
    next_cycle();
    ifu_flush_i     = 1'b0;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("fl_lsu rsp_v", 32'(lsu_rsp_valid_o), 32'd1);
    chk("fl_lsu rsp_d", lsu_rsp_data_o, 32'hA5A5A5A5);

    // reset while waiting for a response, then a stray response
    next_cycle();
    lsu_req_valid_i = 1'b1;
    lsu_addr_i      = 32'h500;
    lsu_we_i        = 1'b1;
    lsu_be_i        = 4'hF;
    lsu_wdata_i     = 32'h77;
    next_cycle();
    clr_inputs();
    mem_req_ready_i = 1'b1;
    next_cycle();
    mem_req_ready_i = 1'b0;
    rstn_i          = 1'b0;
    next_cycle();
    rstn_i          = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hFFFF_0000;
    @(negedge clk_i);
    chk("mrst mem_v", 32'(mem_req_valid_o), 32'd0);
    chk("mrst addr", mem_addr_o, 32'd0);
    chk("mrst we", 32'(mem_we_o), 32'd0);
    chk("mrst be", 32'(mem_be_o), 32'd0);
    chk("mrst wdata", mem_wdata_o, 32'd0);
    chk("mrst ifu_rsp_d", ifu_rsp_data_o, 32'd0);
    chk("mrst lsu_rsp_d", lsu_rsp_data_o, 32'd0);
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    lsu_req_valid_i = 1'b1;
    lsu_addr_i      = 32'h400;
    @(negedge clk_i);
    chk("mrst lsu_rdy", 32'(lsu_req_ready_o), 32'd1);
    chk("mrst ifu_rsp_v", 32'(ifu_rsp_valid_o), 32'd0);
    chk("mrst lsu_rsp_v", 32'(lsu_rsp_valid_o), 32'd0);

    // streak limit: both always valid, always-ready memory
    do_reset();
    ng  = 0;
    acc = 1'b0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      next_cycle();
      ifu_req_valid_i = 1'b1;
      ifu_addr_i      = 32'h1000;
      lsu_req_valid_i = 1'b1;
      lsu_addr_i      = 32'h2000;
      mem_req_ready_i = 1'b1;
      mem_rsp_valid_i = acc;
      mem_rsp_data_i  = 32'(c);
      @(negedge clk_i);
      acc = mem_req_valid_o && mem_req_ready_i;
      if (lsu_req_ready_o) begin
        g[ng] = 1'b1;
        ng++;
      end else if (ifu_req_ready_o) begin
        g[ng] = 1'b0;
        ng++;
      end
    end
    chk("streak grant count", 32'(ng), 32'd10);
    for (int i = 0; i < ng; i++)
      chk($sformatf("streak grant%0d is_lsu", i), 32'(g[i]),
          32'((i % 5) != 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvj1_mem_arb.md
Name: rvj1_mem_arb

Overview:
- Single-port memory arbiter for the rvj1 core.
- Shares one memory request/response port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Allows one outstanding transaction at a time.
- LSU has default priority; a streak limiter guarantees fetch progress.
- Supports IFU flush on redirect, which drops stale fetch responses.

Parameters:
- XLEN, 32, data and address width.
- MAX_LSU_STREAK, 4, consecutive contested LSU grants before the IFU is forced to win (≥1).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; synchronous, active-low
- ifu_req_valid_i  in  1  fetch request valid
- ifu_req_ready_o  out  1  fetch request accepted
- ifu_addr_i  in  XLEN  fetch address
- ifu_flush_i  in  1  discard any in-flight fetch response
- ifu_rsp_valid_o  out  1  fetch data valid (1-cycle pulse)
- ifu_rsp_data_o  out  XLEN  fetched instruction
- lsu_req_valid_i  in  1  LSU request valid
- lsu_req_ready_o  out  1  LSU request accepted
- lsu_addr_i  in  XLEN  LSU address
- lsu_we_i  in  1  1 = store
- lsu_be_i  in  XLEN/8  byte enables
- lsu_wdata_i  in  XLEN  store data
- lsu_rsp_valid_o  out  1  LSU response valid (1-cycle pulse; also pulses for stores)
- lsu_rsp_data_o  out  XLEN  load data
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  XLEN  memory address
- mem_we_o  out  1  write enable
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  write data
- mem_rsp_valid_i  in  1  memory response valid
- mem_rsp_data_i  in  XLEN  memory read data

Behaviour:
- **Reset.** While rstn_i=0 at a clock edge:
  - state←IDLE, owner←IFU, streak←0, drop←0.
  - All mem_* outputs ←0.
  - ifu/lsu_rsp_valid_o←0; rsp data←0.
  - Any in-flight transaction is abandoned. Responses arriving in IDLE are ignored.
- **FSM states:** IDLE, REQ, WAIT_RSP.
- **IDLE:**
  - Ready outputs are combinational and asserted only in IDLE, only toward the winner.
  - Winner = LSU if lsu_req_valid_i and not (ifu_req_valid_i and streak==MAX_LSU_STREAK); otherwise IFU if ifu_req_valid_i.
  - On a grant:
    - Register address, we, be, wdata. For an IFU grant, we←0, be←all ones, wdata←0.
    - mem_req_valid_o←1, owner←winner, go to REQ.
  - No valid request: stay in IDLE, mem_req_valid_o=0.
- **Streak counter:**
  - Increments on an LSU grant when ifu_req_valid_i was also high.
  - Resets to 0 on any IFU grant.
  - Saturates at MAX_LSU_STREAK.
  - An uncontested LSU grant leaves it unchanged.
- **REQ:**
  - Hold mem_* stable with mem_req_valid_o=1 until mem_req_ready_i=1.
  - On acceptance: mem_req_valid_o←0, go to WAIT_RSP.
  - mem_rsp_valid_i in REQ is a protocol violation and is ignored.
- **WAIT_RSP:**
  - On mem_rsp_valid_i, the owner's rsp_valid_o←1 and rsp_data_o←mem_rsp_data_i on the next edge, for exactly one cycle. Go to IDLE.
  - If owner=IFU and (drop=1 or ifu_flush_i=1 in the response cycle), no ifu_rsp_valid_o pulse is generated. drop←0.
- **Flush:**
  - ifu_flush_i while owner=IFU in REQ or WAIT_RSP sets drop←1.
  - The memory transaction still completes; the response is consumed silently.
  - Flush in IDLE, or while owner=LSU, has no effect.
- **Latency:**
  - Request granted at cycle T: mem_req_valid_o high at T+1.
  - Accepted at T+1: earliest mem_rsp_valid_i at T+2.
  - Requester rsp_valid_o at T+3.
  - Next grant possible at T+3, i.e. at most one transaction per 3 cycles.
- rsp_data_o holds its last value between pulses.

Test Plan:
- **LSU priority:** both valid in IDLE, streak=0 → lsu_req_ready_o=1, ifu_req_ready_o=0; mem_addr_o=lsu_addr_i at T+1.
- **Starvation limit:** both continuously valid, memory always ready, 1-cycle response → exactly 4 LSU grants, then 1 IFU grant, repeating.
- **Backpressure:** mem_req_ready_i low for 5 cycles, store 0x0000_1000/0xDEADBEEF/be=4'b0011 → mem_* stable for all 5 cycles; lsu_rsp_valid_o single pulse after the response.
- **Fetch path:** IFU fetch 0x0000_0080, memory returns 0x00000013 → ifu_rsp_valid_o pulse with data 0x00000013 one cycle after mem_rsp_valid_i; lsu_rsp_valid_o stays 0.
- **Flush:**
  - ifu_flush_i in WAIT_RSP, response 0x12345678 → no ifu_rsp_valid_o; FSM back in IDLE, next request granted normally.
  - ifu_flush_i during an LSU transaction → LSU response delivered.
- **Reset mid-transaction:** rstn_i=0 for 1 cycle in WAIT_RSP, then a stray mem_rsp_valid_i → all outputs 0, no rsp pulse, state IDLE.
